rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Built around a rotating 8-to-3 priority pick. It adds grant registration, ownership hold until the owner signals done, a hold-time watchdog and fair pointer rotation.
- Sits between the requesting units and the shared datapath. Downstream muxing uses grant_id.

Parameters:
- N_REQ, 8, number of requesters (fixed at 8 for this revision).
- ID_W, 3, width of grant_id, equal to log2(N_REQ).
- MAX_HOLD, 16, maximum cycles one owner may hold the grant. 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  8  request vector. Bit i is held high by requester i while it wants the resource.
- done  input  1  single-cycle pulse from the current owner releasing the grant. Ignored when no grant is active.
- grant  output  8  registered one-hot grant. All zeros when idle.
- grant_id  output  3  binary index of the current owner. Valid only while grant_valid is high.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  single-cycle pulse when the watchdog forcibly revokes a grant.

Behaviour:
- Reset (rst high at a clock edge): grant=0, grant_id=0, grant_valid=0, timeout=0, state=IDLE, hold_cnt=0, last pointer=7. This gives requester 0 first priority after reset.
- Reset mid-grant drops the grant on the next edge, with no done and no timeout pulse.
- States:
  - IDLE: no owner.
  - BUSY: owner = grant_id.
- Pick function (combinational):
  - Scan indices last+1, last+2, … last+8 (mod 8).
  - The first index with req set wins.
  - No requests means no pick.
- IDLE: if req != 0, register the pick on that edge: grant=onehot(pick), grant_id=pick, grant_valid=1, last=pick, hold_cnt=0, go to BUSY.
  - Latency from req rising to grant is 1 cycle.
- BUSY: hold_cnt increments each cycle. Release fires when any of these holds:
  - (a) done=1;
  - (b) req[grant_id]=0 (owner withdrew);
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
- On a release edge:
  - Re-pick with last=current grant_id, so the old owner has lowest priority.
  - If a pick exists, grant it on that same edge (back-to-back handover, no idle cycle) and stay in BUSY with hold_cnt=0.
  - Otherwise clear grant and grant_valid and go to IDLE.
  - The old owner may win again only if it is the sole requester with req still high.
- timeout is high for exactly the one cycle following a release caused solely by (c). If done or withdraw coincides with (c), the release counts as normal and timeout stays 0.
- Requests that arrive while another owner holds the grant wait. The grant never preempts except through the watchdog.
- grant is always one-hot or zero. grant_id always equals the encoded grant when grant_valid=1.
- All outputs are registered. No combinational path from req or done to any output.

Decomposition:
- Package rr_arb_pkg holds:
  - N_REQ and ID_W constants;
  - the state encoding constants IDLE=1'b0 and BUSY=1'b1;
  - the reset value of the last pointer (7).
- Sub-module rr_priority_pick (combinational):
  - inputs: req[7:0], last[2:0];
  - outputs: pick_id[2:0], pick_valid;
  - implementation: rotate req, 8-to-3 priority encode, un-rotate.
- The top contains the FSM, hold counter and output registers.

Test Plan:
- Reset, then req=8'b0000_0001 -> after 1 cycle grant=8'h01, grant_id=0, grant_valid=1. Pulse done -> next cycle grant=0, grant_valid=0.
- req=8'hFF held, done pulsed every 4 cycles -> grant_id sequence 0,1,2,…,7,0 with no idle cycle between owners.
- req=8'b1000_0100 with owner 2 -> done -> grant_id=7 -> done -> grant_id=2 (wrap-around from 7 to 2).
- MAX_HOLD=16, req=8'h03, owner 0 never pulses done -> at cycle 16 of ownership grant moves to 1, and timeout is high for exactly 1 cycle.
- Owner 3 drops req[3] with req[5] high -> next cycle grant_id=5, timeout=0. Same case with only req[3] -> next cycle grant=0.
- Assert rst while owner 4 holds the grant and req=8'hFF -> grant=0, grant_valid=0. After rst deasserts, the first grant is to requester 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last-owner pointer after reset; makes requester 0 the first in line.
  localparam logic [ID_W-1:0] LAST_RESET = 3'd7;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first set req bit scanning from last+1 upward, wrapping mod 8.
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_valid
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  enc;

  // rot[0] is the requester right after last, so lower rot index = higher priority.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [ID_W-1:0] src_idx;
      assign src_idx = last + ID_W'(gi + 1);
      assign rot[gi] = req[src_idx];
    end
  endgenerate

  always_comb begin
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = ID_W'(i);
    end
  end

  assign pick_valid = |req;
  assign pick_id    = last + enc + ID_W'(1);

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold-until-done ownership and a hold-time watchdog.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [ID_W-1:0]   last_reg, last_next;
  logic [N_REQ-1:0]  grant_reg, grant_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic              grant_valid_reg, grant_valid_next;
  logic              timeout_reg, timeout_next;

  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic              owner_req, wd_hit, release_now;

  // last_reg equals the owner while BUSY, so one pick serves both idle grant and handover.
  rr_priority_pick u_pick (
    .req        (req),
    .last       (last_reg),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  assign owner_req   = req[grant_id_reg];
  assign wd_hit      = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
  assign release_now = done || !owner_req || wd_hit;

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    last_next        = last_reg;
    grant_next       = grant_reg;
    grant_id_next    = grant_id_reg;
    grant_valid_next = grant_valid_reg;
    timeout_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next       = BUSY;
          grant_next       = onehot(pick_id);
          grant_id_next    = pick_id;
          grant_valid_next = 1'b1;
          last_next        = pick_id;
          hold_cnt_next    = '0;
        end
      end
      BUSY: begin
        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        if (release_now) begin
          // Watchdog pulse only when nothing else would have released this cycle.
          timeout_next  = wd_hit && !done && owner_req;
          hold_cnt_next = '0;
          if (pick_valid) begin
            grant_next    = onehot(pick_id);
            grant_id_next = pick_id;
            last_next     = pick_id;
          end else begin
            state_next       = IDLE;
            grant_next       = '0;
            grant_valid_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      last_reg        <= LAST_RESET;
      grant_reg       <= '0;
      grant_id_reg    <= '0;
      grant_valid_reg <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      last_reg        <= last_next;
      grant_reg       <= grant_next;
      grant_id_reg    <= grant_id_next;
      grant_valid_reg <= grant_valid_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_id    = grant_id_reg;
  assign grant_valid = grant_valid_reg;
  assign timeout     = timeout_reg;

endmodule
